// File: rtl/norm_shift_seq_pkg.sv
// norm_shift_seq_pkg
//   Shared definitions for the normalizer: direction encodings, the FSM state
//   type and a constant-friendly log2 helper.
//   No ports (package).
package norm_shift_seq_pkg;

  // Direction encodings on the dir input / mode register
  localparam logic DIR_LEFT  = 1'b0;  // count leading zeros, shift left
  localparam logic DIR_RIGHT = 1'b1;  // count trailing zeros, shift right

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/norm_shift_seq_if.sv
// norm_shift_seq_if
//   Groups the request/response signals of the normalizer.
//   master: drives start, dir, In; observes ready, done, Out, Cnt, zero.
//   slave : the normalizer side (mirror of master).
//   Signals:
//     start - request, taken only while ready is high
//     dir   - 0 left normalize, 1 right normalize
//     In    - operand
//     ready - normalizer can accept a request
//     done  - one-cycle result pulse
//     Out   - normalized value
//     Cnt   - shift amount applied (0..WIDTH)
//     zero  - operand was all zeros
interface norm_shift_seq_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
);

  logic             start;
  logic             dir;
  logic [WIDTH-1:0] In;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] Out;
  logic [CNT_W-1:0] Cnt;
  logic             zero;

  modport master (
    output start, dir, In,
    input  ready, done, Out, Cnt, zero
  );

  modport slave (
    input  start, dir, In,
    output ready, done, Out, Cnt, zero
  );

endinterface

// File: rtl/norm_shift_seq_norm_stage.sv
// norm_stage
//   One combinational binary-search step of the normalizer. Looks at the
//   s-bit field at the end being normalized; if that field is all zeros the
//   word is shifted by s (zero fill) and s is reported as the count increment.
//   Ports:
//     work      in  WIDTH  current working value
//     s         in  CNT_W  step size (a power of two, at most WIDTH/2)
//     dir       in  1      0 left (MSB end), 1 right (LSB end)
//     next_work out WIDTH  shifted value, or work unchanged on no hit
//     hit       out 1      the examined field was all zeros
//     inc       out CNT_W  amount to add to the shift count (s or 0)
import norm_shift_seq_pkg::*;

module norm_stage #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] work,
  input  logic [CNT_W-1:0] s,
  input  logic             dir,
  output logic [WIDTH-1:0] next_work,
  output logic             hit,
  output logic [CNT_W-1:0] inc
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] field_mask;

  // The mask selects the top s bits in left mode and the bottom s bits in
  // right mode; shifting an all-ones word and inverting avoids any variable
  // part-select.
  always_comb begin
    field_mask = '0;
    hit        = 1'b0;
    next_work  = work;
    inc        = '0;
    if (dir == DIR_LEFT) begin
      field_mask = ~(ALL_ONES >> s);
    end else begin
      field_mask = ~(ALL_ONES << s);
    end
    hit = ((work & field_mask) == '0);
    if (hit) begin
      inc = s;
      if (dir == DIR_LEFT) begin
        next_work = work << s;
      end else begin
        next_work = work >> s;
      end
    end
  end

endmodule

// File: rtl/norm_shift_seq.sv
// norm_shift_seq
//   Multi-cycle normalizer. On an accepted start it captures the operand and
//   runs a binary search of shift steps WIDTH/2, ..., 2, 1, finding the
//   leading-zero (left) or trailing-zero (right) count and the normalized
//   value. Results appear with a one-cycle done pulse and hold until the
//   next result.
//   Ports:
//     clk   in  1   clock, rising edge
//     rst_n in  1   asynchronous active-low reset
//     bus   slave   start/dir/In request, ready/done/Out/Cnt/zero response
import norm_shift_seq_pkg::*;

module norm_shift_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  norm_shift_seq_if.slave bus
);

  localparam int               K_W         = clog2(WIDTH);
  localparam logic [K_W-1:0]   K_FIRST     = K_W'(K_W - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO_OP = CNT_W'(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [K_W-1:0]   k;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] count;
  logic             mode;
  logic             zero_op;

  logic [CNT_W-1:0] step;
  logic [WIDTH-1:0] next_work;
  logic             hit;
  logic [CNT_W-1:0] inc;

  logic             ready_int;
  logic             accept;
  logic             last_stage;

  logic [WIDTH-1:0] out_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             zero_reg;

  assign ready_int  = (state != RUN);
  assign accept     = bus.start && ready_int;
  assign last_stage = (state == RUN) && (k == '0);
  assign step       = CNT_W'(1) << k;

  norm_stage #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_stage (
    .work      (work),
    .s         (step),
    .dir       (mode),
    .next_work (next_work),
    .hit       (hit),
    .inc       (inc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DONE accepts a new request directly so a held start
  // streams one result every log2(WIDTH)+1 cycles; start during RUN is dropped.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (k == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Working datapath: capture on accept, then one search step per RUN cycle.
  // The all-zero flag is taken from the operand itself so the final override
  // does not depend on the search result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work    <= '0;
      count   <= '0;
      mode    <= DIR_LEFT;
      k       <= '0;
      zero_op <= 1'b0;
    end else if (accept) begin
      work    <= bus.In;
      count   <= '0;
      mode    <= bus.dir;
      k       <= K_FIRST;
      zero_op <= (bus.In == '0);
    end else if (state == RUN) begin
      work  <= next_work;
      count <= count + inc;
      if (k != '0) begin
        k <= k - K_W'(1);
      end
    end
  end

  // Result registers load on the last search step, i.e. on entry to DONE.
  // A zero operand would otherwise report WIDTH-1, so it is forced to WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg  <= '0;
      cnt_reg  <= '0;
      zero_reg <= 1'b0;
    end else if (last_stage) begin
      if (zero_op) begin
        out_reg  <= '0;
        cnt_reg  <= CNT_ZERO_OP;
        zero_reg <= 1'b1;
      end else begin
        out_reg  <= next_work;
        cnt_reg  <= count + inc;
        zero_reg <= 1'b0;
      end
    end
  end

  assign bus.ready = ready_int;
  assign bus.done  = (state == DONE);
  assign bus.Out   = out_reg;
  assign bus.Cnt   = cnt_reg;
  assign bus.zero  = zero_reg;

endmodule

// File: tb/tb_norm_shift_seq.sv
// tb_norm_shift_seq
//   Directed bench for norm_shift_seq (WIDTH=16). A negedge process compares
//   the DUT every cycle against a transaction-level model; the directed
//   sequence also pins results against hand-computed literals.
module tb_norm_shift_seq;

  localparam int WIDTH = 16;
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int LATENCY = $clog2(WIDTH) + 1;

  logic clk;
  logic rst_n;

  norm_shift_seq_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  norm_shift_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: normalize by the definition, one bit at a time
  function automatic void normModel(input logic [WIDTH-1:0] v, input logic d,
                                    output logic [WIDTH-1:0] o, output int c,
                                    output logic z);
    o = v;
    c = 0;
    z = 1'b0;
    if (v == '0) begin
      o = '0;
      c = WIDTH;
      z = 1'b1;
    end else if (d == 1'b0) begin
      while (o[WIDTH-1] == 1'b0) begin
        o = o << 1;
        c = c + 1;
      end
    end else begin
      while (o[0] == 1'b0) begin
        o = o >> 1;
        c = c + 1;
      end
    end
  endfunction

  // Model state: m_left = -1 idle, 0 result cycle, >0 cycles still searching
  int               m_left = -1;
  logic [WIDTH-1:0] m_out = '0;
  int               m_cnt = 0;
  logic             m_zero = 1'b0;
  logic [WIDTH-1:0] p_out = '0;
  int               p_cnt = 0;
  logic             p_zero = 1'b0;

  // Per-cycle comparison against the model, then advance the model using the
  // inputs that the next rising edge will sample
  always @(negedge clk) begin
    if (!rst_n) begin
      m_left = -1;
      m_out  = '0;
      m_cnt  = 0;
      m_zero = 1'b0;
    end
    checkValue("cyc_ready", 32'(bus.ready), 32'(m_left <= 0));
    checkValue("cyc_done",  32'(bus.done),  32'(m_left == 0));
    checkValue("cyc_out",   32'(bus.Out),   32'(m_out));
    checkValue("cyc_cnt",   32'(bus.Cnt),   32'(m_cnt));
    checkValue("cyc_zero",  32'(bus.zero),  32'(m_zero));
    if (rst_n) begin
      if (m_left <= 0) begin
        if (bus.start) begin
          normModel(bus.In, bus.dir, p_out, p_cnt, p_zero);
          m_left = LATENCY - 1;
        end else begin
          m_left = -1;
        end
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_out  = p_out;
          m_cnt  = p_cnt;
          m_zero = p_zero;
        end
      end
    end
  end

  // Present a one-cycle request; returns 1 time unit after the accepting edge
  task automatic applyStimulus(input logic d, input logic [WIDTH-1:0] v);
    bus.start = 1'b1;
    bus.dir   = d;
    bus.In    = v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.dir   = 1'($urandom);
    bus.In    = 16'($urandom);
  endtask

  // Wait (bounded) for done, then pin latency and results to literals
  task automatic checkOutput(input string name, input logic [WIDTH-1:0] eo,
                             input int ec, input logic ez);
    int edges;
    edges = 1;
    while (bus.done !== 1'b1 && edges < 20) begin
      @(posedge clk);
      #1;
      edges = edges + 1;
    end
    checkValue({name, "_done"},    32'(bus.done), 32'd1);
    checkValue({name, "_latency"}, 32'(edges),    32'd5);
    checkValue({name, "_out"},     32'(bus.Out),  32'(eo));
    checkValue({name, "_cnt"},     32'(bus.Cnt),  32'(ec));
    checkValue({name, "_zero"},    32'(bus.zero), 32'(ez));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dir   = 1'b0;
    bus.In    = '0;
    rst_n     = 1'b1;
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkValue("rst_out",   32'(bus.Out),   32'd0);
    checkValue("rst_cnt",   32'(bus.Cnt),   32'd0);
    checkValue("rst_zero",  32'(bus.zero),  32'd0);
    checkValue("rst_done",  32'(bus.done),  32'd0);
    checkValue("rst_ready", 32'(bus.ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] left and right normalization");
    applyStimulus(1'b0, 16'h0001); checkOutput("l0001", 16'h8000, 15, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b0, 16'h8000); checkOutput("l8000", 16'h8000, 0, 1'b0);
    applyStimulus(1'b0, 16'h00F0); checkOutput("l00F0", 16'hF000, 8, 1'b0);
    applyStimulus(1'b1, 16'h0A00); checkOutput("r0A00", 16'h0005, 9, 1'b0);
    applyStimulus(1'b1, 16'h0001); checkOutput("r0001", 16'h0001, 0, 1'b0);

    $display("[TB] zero operands");
    applyStimulus(1'b0, 16'h0000); checkOutput("l0000", 16'h0000, 16, 1'b1);
    applyStimulus(1'b1, 16'h0000); checkOutput("r0000", 16'h0000, 16, 1'b1);
    applyStimulus(1'b0, 16'h0100); checkOutput("l0100", 16'h8000, 7, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] streaming with start held high");
    bus.start = 1'b1;
    bus.dir   = 1'b0;
    bus.In    = 16'h0003;
    @(posedge clk); #1;
    bus.dir = 1'($urandom); bus.In = 16'($urandom);
    checkOutput("s0003", 16'hC000, 14, 1'b0);
    bus.dir = 1'b1; bus.In = 16'h0F00;
    @(posedge clk); #1;
    bus.dir = 1'($urandom); bus.In = 16'($urandom);
    checkOutput("s0F00", 16'h000F, 8, 1'b0);
    bus.dir = 1'b0; bus.In = 16'h2000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.dir = 1'($urandom); bus.In = 16'($urandom);
    checkOutput("s2000", 16'h8000, 2, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset in the middle of an operation");
    applyStimulus(1'b0, 16'h00F0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("arst_out",   32'(bus.Out),   32'd0);
    checkValue("arst_cnt",   32'(bus.Cnt),   32'd0);
    checkValue("arst_done",  32'(bus.done),  32'd0);
    checkValue("arst_ready", 32'(bus.ready), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 16'h0004); checkOutput("r0004", 16'h0001, 2, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
